sccb_target: RTL

//  SCCB/I2C-style target (camera-side responder) for the SCCB master driver in this design.

---
 rtl/sccb_pkg.sv | 34 +++
 rtl/sccb_bus_sync.sv | 51 +++++
 rtl/sccb_target.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the SCCB target.
//   sccb_state_t : byte-level FSM states
//   DEV_ID_DEF   : default 7-bit device ID (0x78 write / 0x79 read)
//   BYTE_BITS    : data bits per byte; ACK_BIT : bit index of the ninth (ACK) slot
//   sccb_wr_t    : register-file write request (address + data)
package sccb_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV_ID,
      ST_ACK,
      ST_ADDR_H,
      ST_ADDR_L,
      ST_WDATA,
      ST_RDATA,
      ST_RACK,
      ST_IGNORE
   } sccb_state_t;

   localparam logic [6:0] DEV_ID_DEF = 7'h3C;
   localparam logic [3:0] BYTE_BITS  = 4'd8;
   localparam logic [3:0] ACK_BIT    = 4'd8;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } sccb_wr_t;

   // ID byte carries the device ID in [7:1] and R/W in [0]
   function automatic logic id_match(input logic [7:0] id_byte, input logic [6:0] id);
      return id_byte[7:1] == id;
   endfunction

endpackage

// File: rtl/sccb_bus_sync.sv
// sccb_bus_sync: synchronises the asynchronous scl/sda lines and derives
// bus events one clock after the synchronised level changes.
//   clk, rst_n            : system clock, async active-low reset
//   scl_in, sda_in        : raw bus lines
//   scl_rise, scl_fall    : one-clk pulses on synchronised scl edges
//   start_det, stop_det   : sda fall / rise while scl is held high
//   sda_s                 : synchronised sda level
module sccb_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_q;
   logic                   sda_q;
   logic                   scl_s;

   // Reset to the idle bus level so leaving reset never looks like an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_q    <= scl_sync[SYNC_STAGES-1];
         sda_q    <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  =  scl_s & ~scl_q;
   assign scl_fall  = ~scl_s &  scl_q;
   // scl must be high in both samples so an scl edge never aliases as START/STOP
   assign start_det =  scl_s & scl_q &  sda_q & ~sda_s;
   assign stop_det  =  scl_s & scl_q & ~sda_q &  sda_s;

endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C-style register target.
// Decodes ID+W, addr_h, addr_l, data... writes and ID+R, data... reads,
// issuing register-file write strobes and read requests.
//   clk, rst_n        : system clock, async active-low reset
//   scl_in, sda_in    : bus lines (sda_in is the wire level)
//   sda_oe            : 1 = pull sda low (ACK or read-data 0)
//   wr_en/addr/data   : one-clk register write
//   rd_req/rd_addr    : one-clk read request; rd_data valid 1 clk later
//   busy              : between START and STOP
module sccb_target
   import sccb_pkg::*;
#(
   parameter logic [6:0] DEV_ID      = DEV_ID_DEF,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        rd_req,
   output logic [15:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic        busy
);

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   sccb_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   sccb_state_t state, state_nxt, ack_next, ack_tgt;
   logic [3:0]  bit_cnt;
   logic [7:0]  shift;
   logic [7:0]  addr_hi;
   logic [15:0] pointer;
   logic [7:0]  rd_byte;
   logic        rd_latch;
   sccb_wr_t    wr_q;

   logic [7:0]  byte_in;
   logic        last_bit;
   logic        ack_fall;
   logic        wr_fire;
   logic        rd_fire;
   logic [15:0] rd_ptr;

   assign byte_in  = {shift[6:0], sda_s};
   assign last_bit = scl_rise && (bit_cnt == BYTE_BITS - 4'd1);
   assign ack_fall = scl_fall && (bit_cnt == ACK_BIT);
   assign wr_addr  = wr_q.addr;
   assign wr_data  = wr_q.data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wr_fire   = 1'b0;
      rd_fire   = 1'b0;
      rd_ptr    = pointer;
      ack_tgt   = ST_WDATA;
      case (state)
         ST_DEV_ID: ack_tgt = shift[0] ? ST_RDATA : ST_ADDR_H;
         ST_ADDR_H: ack_tgt = ST_ADDR_L;
         default:   ack_tgt = ST_WDATA;
      endcase

      if (stop_det) begin
         state_nxt = ST_IDLE;
      end else if (start_det) begin
         // repeated START restarts decode; partial byte is simply dropped
         state_nxt = ST_DEV_ID;
      end else begin
         case (state)
            ST_DEV_ID: begin
               if (last_bit) begin
                  if (!id_match(byte_in, DEV_ID)) state_nxt = ST_IGNORE;
                  else if (byte_in[0])            rd_fire   = 1'b1;
               end else if (ack_fall) begin
                  state_nxt = ST_ACK;
               end
            end
            ST_ADDR_H, ST_ADDR_L: if (ack_fall) state_nxt = ST_ACK;
            ST_WDATA: begin
               wr_fire = last_bit;
               if (ack_fall) state_nxt = ST_ACK;
            end
            ST_ACK:   if (scl_fall) state_nxt = ack_next;
            ST_RDATA: if (ack_fall) state_nxt = ST_RACK;
            ST_RACK: begin
               if (scl_rise) begin
                  if (sda_s) begin
                     state_nxt = ST_IGNORE;
                  end else begin
                     // master ACK: prefetch the next byte
                     rd_fire = 1'b1;
                     rd_ptr  = pointer + 16'd1;
                  end
               end else if (scl_fall) begin
                  state_nxt = ST_RDATA;
               end
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         wr_en    <= 1'b0;
         wr_q     <= '0;
         rd_req   <= 1'b0;
         rd_addr  <= '0;
         rd_latch <= 1'b0;
         rd_byte  <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         addr_hi  <= '0;
         pointer  <= '0;
         ack_next <= ST_IDLE;
      end else begin
         wr_en    <= 1'b0;
         rd_req   <= 1'b0;
         rd_latch <= rd_req;
         if (rd_latch) rd_byte <= rd_data;

         if (stop_det) begin
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= '0;
         end else if (start_det) begin
            sda_oe  <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
         end else begin
            if (wr_fire) begin
               wr_en     <= 1'b1;
               wr_q.addr <= pointer;
               wr_q.data <= byte_in;
               pointer   <= pointer + 16'd1;
            end
            if (rd_fire) begin
               rd_req  <= 1'b1;
               rd_addr <= rd_ptr;
               pointer <= rd_ptr;
            end

            case (state)
               ST_DEV_ID, ST_ADDR_H, ST_ADDR_L, ST_WDATA: begin
                  if (scl_rise && bit_cnt < BYTE_BITS) begin
                     shift   <= byte_in;
                     bit_cnt <= bit_cnt + 4'd1;
                  end
                  // pointer only changes once the full address has arrived,
                  // so a START after addr_h leaves the old pointer intact
                  if (last_bit && state == ST_ADDR_H) addr_hi <= byte_in;
                  if (last_bit && state == ST_ADDR_L) pointer <= {addr_hi, byte_in};
                  if (ack_fall) begin
                     sda_oe   <= 1'b1;
                     ack_next <= ack_tgt;
                  end
               end
               ST_ACK: begin
                  if (scl_fall) begin
                     bit_cnt <= '0;
                     sda_oe  <= (ack_next == ST_RDATA) ? ~rd_byte[7] : 1'b0;
                  end
               end
               ST_RDATA: begin
                  if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                  if (scl_fall) begin
                     // bit_cnt bits already clocked out; 7-n == ~n in 3 bits
                     if (bit_cnt == ACK_BIT) sda_oe <= 1'b0;
                     else                    sda_oe <= ~rd_byte[~bit_cnt[2:0]];
                  end
               end
               ST_RACK: begin
                  if (scl_fall) begin
                     bit_cnt <= '0;
                     sda_oe  <= ~rd_byte[7];
                  end
               end
               default: sda_oe <= 1'b0;
            endcase
         end
      end
   end

endmodule
